// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - fetch/data arbiter in front of one single-ported synchronous-read word memory
module imem_dmem_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DRD,
    OWN_DWR
  } owner_t;

  owner_t           owner, owner_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             force_if;
  logic             grant_d;
  logic             grant_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    force_if   = 1'b0;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    owner_nxt  = OWN_NONE;
    starve_nxt = starve_cnt;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_addr   = '0;
    mem_wdata  = '0;
    if_valid   = 1'b0;
    if_rdata   = '0;
    d_valid    = 1'b0;
    d_rdata    = '0;

    // Fetch overrides data once data has won STARVE_LIMIT times in a row.
    force_if = if_req && (starve_cnt == CNT_MAX);
    grant_d  = !rst && d_req && !force_if;
    grant_if = !rst && if_req && !grant_d;

    if (grant_d) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      owner_nxt = d_we ? OWN_DWR : OWN_DRD;
    end else if (grant_if) begin
      if_gnt    = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      owner_nxt = OWN_IF;
    end

    if (!if_req || grant_if) begin
      starve_nxt = '0;
    end else if (grant_d && (starve_cnt != CNT_MAX)) begin
      starve_nxt = starve_cnt + 1'b1;
    end

    // A response owed from before a reset cycle is dropped.
    if (!rst) begin
      case (owner)
        OWN_IF: begin
          if_valid = 1'b1;
          if_rdata = mem_rdata;
        end
        OWN_DRD: begin
          d_valid = 1'b1;
          d_rdata = mem_rdata;
        end
        OWN_DWR: begin
          d_valid = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - directed and randomized checks of imem_dmem_arbiter against a word-level memory model
module tb_imem_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int SL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Single-ported, write-first synchronous RAM with a preload port for the bench.
  logic [DW-1:0] ram [64];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] wmerge;

  always_comb wmerge = merge(ram[mem_addr], mem_wdata, mem_be);

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= wmerge;
      mem_rdata <= mem_we ? wmerge : ram[mem_addr];
    end
  end

  logic [DW-1:0] shadow [64];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'b0000;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = v;
    shadow[a] = v;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    if_req = 1'b1; if_addr = 6'd9;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 6'd4; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if ({if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, mem_be, mem_addr, mem_wdata});
    end
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    total++;
    if ({if_valid, d_valid, mem_en} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got %b want 000", {if_valid, d_valid, mem_en});
    end
    tick();
  endtask

  task automatic test_fetch_alone();
    poke(6'd5, 32'h00500093);
    if_req = 1'b1; if_addr = 6'd5;
    @(negedge clk);
    total++;
    if ({if_gnt, d_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 6'd5}) begin
      bad++;
      $display("FAIL fetch_grant: got %b want 10105", {if_gnt, d_gnt, mem_en, mem_we, mem_addr});
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({if_valid, if_rdata, d_valid} !== {1'b1, 32'h00500093, 1'b0}) begin
      bad++;
      $display("FAIL fetch_resp: got v=%b d=%h dv=%b want v=1 d=00500093 dv=0", if_valid, if_rdata, d_valid);
    end
    tick();
  endtask

  task automatic test_contention();
    poke(6'd1, 32'hCAFE0001);
    poke(6'd2, 32'hBEEF0002);
    if_req = 1'b1; if_addr = 6'd2;
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd1;
    @(negedge clk);
    total++;
    if ({d_gnt, if_gnt, mem_addr} !== {1'b1, 1'b0, 6'd1}) begin
      bad++;
      $display("FAIL contend_first: got dg=%b ig=%b a=%0d want dg=1 ig=0 a=1", d_gnt, if_gnt, mem_addr);
    end
    tick();
    d_req = 1'b0;
    @(negedge clk);
    total++;
    if ({d_valid, d_rdata, if_gnt, mem_addr} !== {1'b1, 32'hCAFE0001, 1'b1, 6'd2}) begin
      bad++;
      $display("FAIL contend_second: got dv=%b dr=%h ig=%b a=%0d want 1 cafe0001 1 2", d_valid, d_rdata, if_gnt, mem_addr);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({if_valid, if_rdata, d_valid} !== {1'b1, 32'hBEEF0002, 1'b0}) begin
      bad++;
      $display("FAIL contend_fetch_resp: got v=%b d=%h dv=%b want 1 beef0002 0", if_valid, if_rdata, d_valid);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [5:0] exp_d;
    exp_d = 6'b011011;  // bit i = data wins in cycle i: D D IF D D IF
    if_req = 1'b1; if_addr = 6'd10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({d_gnt, if_gnt} !== {exp_d[i], ~exp_d[i]}) begin
        bad++;
        $display("FAIL starve_cycle%0d: got dg=%b ig=%b want dg=%b ig=%b", i, d_gnt, if_gnt, exp_d[i], ~exp_d[i]);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_store_fetch();
    poke(6'd3, 32'h11223344);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 6'd3; d_wdata = 32'hAABBCCDD;
    @(negedge clk);
    total++;
    if ({d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 4'b0011, 6'd3, 32'hAABBCCDD}) begin
      bad++;
      $display("FAIL store_grant: got g=%b we=%b be=%b a=%0d wd=%h", d_gnt, mem_we, mem_be, mem_addr, mem_wdata);
    end
    tick();
    shadow[3] = 32'h1122CCDD;
    idle();
    if_req = 1'b1; if_addr = 6'd3;
    @(negedge clk);
    total++;
    if ({d_valid, d_rdata, if_gnt, mem_we, mem_be} !== {1'b1, 32'h0, 1'b1, 1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL store_resp: got dv=%b dr=%h ig=%b we=%b be=%b want 1 0 1 0 0000", d_valid, d_rdata, if_gnt, mem_we, mem_be);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({if_valid, if_rdata} !== {1'b1, 32'h1122CCDD}) begin
      bad++;
      $display("FAIL store_readback: got v=%b d=%h want 1 1122ccdd", if_valid, if_rdata);
    end
    tick();
  endtask

  task automatic test_pipelined_fetch();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        if_req = 1'b1; if_addr = AW'(i);
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 4) begin
        total++;
        if ({if_gnt, mem_addr} !== {1'b1, AW'(i)}) begin
          bad++;
          $display("FAIL pipe_grant%0d: got g=%b a=%0d want g=1 a=%0d", i, if_gnt, mem_addr, i);
        end
      end
      if (i > 0) begin
        total++;
        if ({if_valid, if_rdata} !== {1'b1, shadow[i-1]}) begin
          bad++;
          $display("FAIL pipe_resp%0d: got v=%b d=%h want v=1 d=%h", i, if_valid, if_rdata, shadow[i-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd7;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_grant: got %b want 1", d_gnt);
    end
    tick();
    idle();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 6'd8;
    @(negedge clk);
    total++;
    if ({d_valid, if_valid, if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL rstmid_quiet: got %h want 0",
               {d_valid, if_valid, if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({if_gnt, mem_en, mem_addr, d_valid} !== {1'b1, 1'b1, 6'd8, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_after: got ig=%b en=%b a=%0d dv=%b want 1 1 8 0", if_gnt, mem_en, mem_addr, d_valid);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({if_valid, if_rdata} !== {1'b1, shadow[8]}) begin
      bad++;
      $display("FAIL rstmid_resp: got v=%b d=%h want 1 %h", if_valid, if_rdata, shadow[8]);
    end
    tick();
  endtask

  // Reference: whoever was granted last cycle gets the word as it stood after all earlier stores.
  task automatic test_random();
    int          run_d;
    int          prev_kind;   // 0 none, 1 fetch, 2 load, 3 store
    logic [31:0] prev_data;
    logic        eg_d, eg_if;
    logic [47:0] exp_g, act_g;
    logic [65:0] exp_r, act_r;
    run_d = 0;
    prev_kind = 0;
    prev_data = '0;
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 49) == 0);
      if_req  = $urandom_range(0, 3) != 0;
      if_addr = AW'($urandom);
      d_req   = $urandom_range(0, 2) != 0;
      d_we    = $urandom_range(0, 1) == 1;
      d_be    = 4'($urandom);
      d_addr  = AW'($urandom);
      d_wdata = $urandom;
      @(negedge clk);
      eg_d  = !rst && d_req && !(if_req && run_d >= SL);
      eg_if = !rst && if_req && !eg_d;
      exp_g = {eg_if, eg_d, eg_d | eg_if, eg_d & d_we, eg_d ? d_be : 4'b0,
               eg_d ? d_addr : (eg_if ? if_addr : 6'd0), eg_d ? d_wdata : 32'd0};
      act_g = {if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, eg_if ? 32'd0 : mem_wdata};
      total++;
      if (act_g !== exp_g) begin
        bad++;
        $display("FAIL rand_grant c=%0d: got %h want %h", c, act_g, exp_g);
      end
      exp_r = '0;
      if (!rst) begin
        if (prev_kind == 1) exp_r = {1'b1, prev_data, 1'b0, 32'd0};
        if (prev_kind == 2) exp_r = {1'b0, 32'd0, 1'b1, prev_data};
        if (prev_kind == 3) exp_r = {1'b0, 32'd0, 1'b1, 32'd0};
      end
      act_r = {if_valid, if_rdata, d_valid, d_rdata};
      total++;
      if (act_r !== exp_r) begin
        bad++;
        $display("FAIL rand_resp c=%0d: got %h want %h", c, act_r, exp_r);
      end
      prev_kind = 0;
      prev_data = '0;
      if (eg_if) begin
        prev_kind = 1;
        prev_data = shadow[if_addr];
      end else if (eg_d && !d_we) begin
        prev_kind = 2;
        prev_data = shadow[d_addr];
      end else if (eg_d) begin
        prev_kind = 3;
        shadow[d_addr] = merge(shadow[d_addr], d_wdata, d_be);
      end
      if (rst || !if_req || eg_if) run_d = 0;
      else if (eg_d) run_d = run_d + 1;
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    idle();
    tick();
    for (int i = 0; i < 64; i++) begin
      pl_en = 1'b1;
      pl_addr = AW'(i);
      pl_data = $urandom;
      shadow[i] = pl_data;
      tick();
    end
    pl_en = 1'b0;
    test_reset();
    test_fetch_alone();
    test_contention();
    test_starvation();
    test_store_fetch();
    test_pipelined_fetch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported, synchronous-read word memory between the instruction-fetch port and the load/store data port of the femtoRV32 core.
- Lets instruction and data memory be merged into one array, so programs can also be written through stores.
- Issues at most one memory access per cycle and grants data over fetch by fixed priority, with a starvation limit.
- Returns read data one cycle after grant, steered to the owning port with a valid pulse.

Parameters:
- ADDR_W, 6, word-address width (64 words).
- DATA_W, 32, data word width.
- STARVE_LIMIT, 2, maximum consecutive data grants while if_req is pending before fetch is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted this cycle.
- if_valid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held with all d_* inputs until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables for stores.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_valid  out  1  one-cycle pulse; load data valid, or store complete.
- d_rdata  out  DATA_W  load data; 0 on store completion.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after an enabled read.

Behaviour:
- Grant logic:
  - Combinational from the current requests and the registered state.
  - mem_* outputs are driven from the granted port in the same cycle.
  - With no grant: mem_en=0, mem_we=0, mem_be=0, other mem_* outputs 0.
- Priority:
  - d_req wins over if_req, except when starve_cnt==STARVE_LIMIT and if_req=1; then fetch wins.
- starve_cnt (saturating, width clog2(STARVE_LIMIT+1)):
  - Increments on a data grant while if_req=1.
  - Clears on any fetch grant, or on any cycle with if_req=0.
- Owner FSM, registered each cycle from that cycle's grant, with four states:
  - OWN_NONE.
  - OWN_IF.
  - OWN_DRD.
  - OWN_DWR.
- Response, driven in the cycle after the grant, from the owner state:
  - OWN_IF: if_valid=1, if_rdata=mem_rdata.
  - OWN_DRD: d_valid=1, d_rdata=mem_rdata.
  - OWN_DWR: d_valid=1, d_rdata=0.
  - OWN_NONE: no valid pulse.
  - If_rdata and d_rdata read 0 whenever their valid is low.
- Throughput: one grant per cycle, fully pipelined. Grant in cycle N gives response in N+1, while a new grant in N+1 is allowed.
- Store path: mem_we=d_we, mem_be=d_be, and mem_wdata=d_wdata on a data grant. Fetch grants force mem_we=0 and mem_be=0.
- Simultaneous events:
  - A grant and a response to a different port may occur in the same cycle.
  - A store granted in cycle N followed by a fetch of the same address in N+1 returns the newly written data. Read-after-write ordering is guaranteed by the memory's write-first behaviour on clk.
- Requester protocol:
  - A request dropped before its grant is never issued.
  - Address and data changes while a request is ungranted take effect only at grant.
- Reset, with rst=1 at a rising edge:
  - Owner returns to OWN_NONE and starve_cnt to 0.
  - During the rst cycle, all grant, valid and mem_* outputs are 0, regardless of requests.
  - A response pending from the cycle before reset is dropped; no valid pulse follows.
  - First grant possible in the first cycle with rst=0.

Test Plan:
- Fetch alone: if_req=1, if_addr=5, mem[5]=0x00500093 → if_gnt in cycle N, mem_en=1, mem_addr=5; if_valid=1, if_rdata=0x00500093 in N+1.
- Contention: if_req=1 (addr 2) and d_req=1 load (addr 1) in the same cycle → d_gnt first, d_valid next cycle with mem[1]; if_gnt one cycle after d_gnt.
- Starvation, STARVE_LIMIT=2: d_req and if_req both held for 6 cycles, with d_req re-asserted after each grant → grant sequence D, D, IF, D, D, IF.
- Store then fetch: store d_be=4'b0011, addr 3, d_wdata=0xAABBCCDD, mem[3]=0x11223344 → mem_we=1, mem_be=0011; d_valid with d_rdata=0 next cycle; a following fetch of addr 3 returns 0x1122CCDD.
- Pipelined fetch: if_req held while if_addr steps 0, 1, 2, 3 → if_gnt each cycle; if_valid each cycle one behind, with mem[0..3] in order.
- Reset mid-operation: d_gnt on a load in cycle N, rst=1 in N+1 → d_valid=0 and all mem_* outputs 0 in N+1; normal grant in the first cycle after rst falls.
